// File: rtl/npc_pc_ras.sv
// rtl/npc_pc_ras.sv - F-stage PC register, next-PC select and return-address stack
// Optional jr hit/miss performance counters are built when NPC_PERF_CNT_EN is defined.
module npc_pc_ras #(
  parameter int          RAS_DEPTH = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic [3:0]                       npc_op,
  input  logic [31:0]                      ins,
  input  logic [31:0]                      pc_d,
  input  logic [31:0]                      rs,
  input  logic                             equ,
  input  logic                             zero_greater,
  input  logic                             zero_equ,
  input  logic                             zero_less,
  input  logic                             exc_req,
  input  logic                             eret,
  input  logic [31:0]                      epc,
  output logic [31:0]                      pc_f,
  output logic [31:0]                      npc,
  output logic [31:0]                      pc8,
  output logic                             ras_hit,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic [31:0]                      jr_hit_cnt,
  output logic [31:0]                      jr_miss_cnt
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [3:0] OP_PC4  = 4'd0;
  localparam logic [3:0] OP_BEQ  = 4'd1;
  localparam logic [3:0] OP_JAL  = 4'd2;
  localparam logic [3:0] OP_JR   = 4'd3;
  localparam logic [3:0] OP_BGEZ = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_BLEZ = 4'd6;
  localparam logic [3:0] OP_BLTZ = 4'd7;
  localparam logic [3:0] OP_BGTZ = 4'd8;
  localparam logic [3:0] OP_JALR = 4'd9;
  localparam logic [3:0] OP_J    = 4'd10;

  logic [31:0]      pc4;
  logic [31:0]      br_target;
  logic [31:0]      jump_target;
  logic             br_taken;
  logic             accepted;
  logic             ras_push;
  logic             ras_pop;
  logic [31:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] top_idx;
  logic [31:0]      ras_top;
  logic             unused_ins;

  // Opcode/function bits are decoded upstream into npc_op.
  assign unused_ins = ^ins[31:26];

  assign pc4         = pc_f + 32'd4;
  assign pc8         = pc_d + 32'd8;
  assign br_target   = pc_d + 32'd4 + {{14{ins[15]}}, ins[15:0], 2'b00};
  assign jump_target = {pc_d[31:28], ins[25:0], 2'b00};

  always_comb begin
    br_taken = 1'b0;
    case (npc_op)
      OP_BEQ:  br_taken = equ;
      OP_BNE:  br_taken = !equ;
      OP_BGEZ: br_taken = zero_greater | zero_equ;
      OP_BLEZ: br_taken = zero_equ | zero_less;
      OP_BLTZ: br_taken = zero_less;
      OP_BGTZ: br_taken = zero_greater;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    npc = pc4;
    case (npc_op)
      OP_PC4:           npc = pc4;
      OP_JAL, OP_J:     npc = jump_target;
      OP_JR, OP_JALR:   npc = rs;
      default:          npc = br_taken ? br_target : pc4;
    endcase
  end

  // The pointer addresses the next free slot; the top is the slot just below it.
  assign top_idx = ras_ptr - PTR_W'(1);
  assign ras_top = ras_mem[top_idx];
  assign ras_hit = (npc_op == OP_JR) && (ras_count != '0) && (ras_top == rs);

  assign accepted = !reset && !exc_req && !eret && !stall;
  assign ras_push = accepted && ((npc_op == OP_JAL) || (npc_op == OP_JALR));
  assign ras_pop  = accepted && (npc_op == OP_JR) && (ras_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else if (exc_req) begin
      pc_f <= EXC_PC;
    end else if (eret) begin
      pc_f <= epc;
    end else if (!stall) begin
      pc_f <= npc;
    end
  end

  // Overflow wraps the pointer so the oldest return address is overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_count != CNT_W'(RAS_DEPTH)) begin
        ras_count <= ras_count + CNT_W'(1);
      end
    end else if (ras_pop) begin
      ras_ptr   <= top_idx;
      ras_count <= ras_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_ptr] <= pc8;
    end
  end

`ifdef NPC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      jr_hit_cnt  <= 32'h0;
      jr_miss_cnt <= 32'h0;
    end else if (accepted && (npc_op == OP_JR)) begin
      if (ras_hit) begin
        jr_hit_cnt <= jr_hit_cnt + 32'd1;
      end else begin
        jr_miss_cnt <= jr_miss_cnt + 32'd1;
      end
    end
  end
`else
  assign jr_hit_cnt  = 32'h0;
  assign jr_miss_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_npc_pc_ras.sv
// tb/tb_npc_pc_ras.sv - self-checking bench for npc_pc_ras (vector table plus scoreboard)
module tb_npc_pc_ras;

  localparam int          DEPTH  = 8;
  localparam int          CNT_W  = $clog2(DEPTH + 1);
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_A  = 32'h0000_4180;
`ifdef NPC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [3:0] PC4 = 4'd0, BEQ = 4'd1, JAL = 4'd2, JR = 4'd3, BGEZ = 4'd4, BNE = 4'd5;
  localparam logic [3:0] BLEZ = 4'd6, BLTZ = 4'd7, BGTZ = 4'd8, JALR = 4'd9, JMP = 4'd10;

  logic             clk = 1'b0;
  logic             reset, stall, equ, zero_greater, zero_equ, zero_less, exc_req, eret;
  logic [3:0]       npc_op;
  logic [31:0]      ins, pc_d, rs, epc;
  logic [31:0]      pc_f, npc, pc8, jr_hit_cnt, jr_miss_cnt;
  logic             ras_hit;
  logic [CNT_W-1:0] ras_count;

  npc_pc_ras #(.RAS_DEPTH(DEPTH), .RESET_PC(RST_PC), .EXC_PC(EXC_A)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .ins(ins), .pc_d(pc_d),
    .rs(rs), .equ(equ), .zero_greater(zero_greater), .zero_equ(zero_equ),
    .zero_less(zero_less), .exc_req(exc_req), .eret(eret), .epc(epc), .pc_f(pc_f),
    .npc(npc), .pc8(pc8), .ras_hit(ras_hit), .ras_count(ras_count),
    .jr_hit_cnt(jr_hit_cnt), .jr_miss_cnt(jr_miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] ins;
    logic [31:0] pc_d;
    logic [31:0] rs;
    logic [3:0]  fl;
    logic [31:0] exp_npc;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] pc_f;
    int          cnt;
    logic [31:0] hit;
    logic [31:0] miss;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc;
  logic [31:0] m_hit, m_miss;
  vec_t        tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_npc(input logic [3:0] op, input logic [31:0] i_ins,
                                          input logic [31:0] pcd, input logic [31:0] i_rs,
                                          input logic [3:0] fl, input logic [31:0] pcf);
    logic [31:0] off;
    logic        e, g, z, l, t;
    off = {{14{i_ins[15]}}, i_ins[15:0], 2'b00};
    {e, g, z, l} = fl;
    t = 1'b0;
    if (op == BEQ)  t = e;
    if (op == BNE)  t = !e;
    if (op == BGEZ) t = g | z;
    if (op == BLEZ) t = z | l;
    if (op == BLTZ) t = l;
    if (op == BGTZ) t = g;
    if (op == JAL || op == JMP) return {pcd[31:28], i_ins[25:0], 2'b00};
    if (op == JR || op == JALR) return i_rs;
    return t ? (pcd + 32'd4 + off) : (pcf + 32'd4);
  endfunction

  // Drive one cycle, check combinational outputs mid-cycle, queue the expected registered state.
  task automatic step(input logic [3:0] op, input logic [31:0] i_ins, input logic [31:0] pcd,
                      input logic [31:0] i_rs, input logic [3:0] fl, input logic st,
                      input logic ex, input logic er, input logic [31:0] i_epc,
                      input logic [31:0] exp_npc, input string tag);
    exp_t e;
    logic hit;
    npc_op = op; ins = i_ins; pc_d = pcd; rs = i_rs;
    {equ, zero_greater, zero_equ, zero_less} = fl;
    stall = st; exc_req = ex; eret = er; epc = i_epc;
    #3;
    hit = 1'b0;
    if (op == JR && m_ras.size() > 0) hit = (m_ras[$] == i_rs);
    chk({tag, ".npc"}, npc, exp_npc);
    chk({tag, ".pc8"}, pc8, pcd + 32'd8);
    chk({tag, ".ras_hit"}, {31'd0, ras_hit}, {31'd0, hit});
    if (ex)        m_pc = EXC_A;
    else if (er)   m_pc = i_epc;
    else if (!st)  m_pc = exp_npc;
    if (!ex && !er && !st) begin
      if (op == JAL || op == JALR) begin
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(pcd + 32'd8);
      end else if (op == JR) begin
        if (PERF) begin
          if (hit) m_hit++;
          else     m_miss++;
        end
        if (m_ras.size() > 0) void'(m_ras.pop_back());
      end
    end
    e.tag = tag; e.pc_f = m_pc; e.cnt = m_ras.size(); e.hit = m_hit; e.miss = m_miss;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc_f"}, pc_f, e.pc_f);
    chk({e.tag, ".ras_count"}, 32'(ras_count), e.cnt);
    chk({e.tag, ".hit_cnt"}, jr_hit_cnt, e.hit);
    chk({e.tag, ".miss_cnt"}, jr_miss_cnt, e.miss);
  endtask

  task automatic seq(input logic [3:0] op, input logic [31:0] i_ins, input logic [31:0] pcd,
                     input logic [31:0] i_rs, input logic st, input string tag);
    step(op, i_ins, pcd, i_rs, 4'b0000, st, 1'b0, 1'b0, 32'h0,
         ref_npc(op, i_ins, pcd, i_rs, 4'b0000, m_pc), tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{"beq_t",    BEQ,  32'h1000_FFFF, 32'h0000_3004, 32'h0, 4'b1000, 32'h0000_3004};
    tbl[1]  = '{"beq_nt",   BEQ,  32'h1000_FFFF, 32'h0000_3004, 32'h0, 4'b0000, 32'h0000_300C};
    tbl[2]  = '{"bne_t",    BNE,  32'h1000_0010, 32'h0000_3004, 32'h0, 4'b0000, 32'h0000_3048};
    tbl[3]  = '{"bne_nt",   BNE,  32'h1000_0010, 32'h0000_3004, 32'h0, 4'b1000, 32'h0000_300C};
    tbl[4]  = '{"bgez_gt",  BGEZ, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b0100, 32'h0000_3010};
    tbl[5]  = '{"bgez_eq",  BGEZ, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b0010, 32'h0000_3010};
    tbl[6]  = '{"bgez_lt",  BGEZ, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b0001, 32'h0000_300C};
    tbl[7]  = '{"blez_eq",  BLEZ, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b0010, 32'h0000_3010};
    tbl[8]  = '{"blez_lt",  BLEZ, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b0001, 32'h0000_3010};
    tbl[9]  = '{"blez_gt",  BLEZ, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b0100, 32'h0000_300C};
    tbl[10] = '{"bltz_t",   BLTZ, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b0001, 32'h0000_3010};
    tbl[11] = '{"bltz_nt",  BLTZ, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b0010, 32'h0000_300C};
    tbl[12] = '{"bgtz_t",   BGTZ, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b0100, 32'h0000_3010};
    tbl[13] = '{"bgtz_nt",  BGTZ, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b1011, 32'h0000_300C};
    tbl[14] = '{"j",        JMP,  32'h0800_0C10, 32'hA000_3004, 32'h0, 4'b0000, 32'hA000_3040};
    tbl[15] = '{"jr_empty", JR,   32'h0,         32'h0000_3004, 32'h1234_5678, 4'b0000, 32'h1234_5678};
    tbl[16] = '{"jalr_st",  JALR, 32'h0,         32'h0000_3004, 32'hDEAD_BEEC, 4'b0000, 32'hDEAD_BEEC};
    tbl[17] = '{"op11",     4'd11, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b1111, 32'h0000_300C};
    tbl[18] = '{"op15",     4'd15, 32'h1000_0002, 32'h0000_3004, 32'h0, 4'b1111, 32'h0000_300C};
    tbl[19] = '{"wrap0",    BEQ,  32'h1000_0000, 32'hFFFF_FFF8, 32'h0, 4'b1000, 32'hFFFF_FFFC};
    tbl[20] = '{"wrap1",    BEQ,  32'h1000_0001, 32'hFFFF_FFF8, 32'h0, 4'b1000, 32'h0000_0000};
    tbl[21] = '{"pc4_st",   PC4,  32'h1000_0002, 32'h0000_3004, 32'h0, 4'b1111, 32'h0000_300C};

    reset = 1'b1; stall = 1'b0; npc_op = PC4; ins = '0; pc_d = '0; rs = '0; epc = '0;
    {equ, zero_greater, zero_equ, zero_less} = 4'b0000; exc_req = 1'b0; eret = 1'b0;
    m_hit = '0; m_miss = '0; m_pc = RST_PC;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset.pc_f", pc_f, RST_PC);
    chk("reset.ras_count", 32'(ras_count), 32'd0);
    chk("reset.hit_cnt", jr_hit_cnt, 32'd0);
    chk("reset.miss_cnt", jr_miss_cnt, 32'd0);

    seq(PC4, 32'h0, 32'h0, 32'h0, 1'b0, "pc4_a");
    seq(PC4, 32'h0, 32'h0, 32'h0, 1'b0, "pc4_b");
    chk("pc4.pc_f", pc_f, 32'h0000_3008);

    // pc_f is held at 0x3008 for the whole table, so default npc is 0x300C.
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].op, tbl[i].ins, tbl[i].pc_d, tbl[i].rs, tbl[i].fl, 1'b1, 1'b0, 1'b0, 32'h0,
           tbl[i].exp_npc, tbl[i].name);
    end

    seq(JAL, 32'h0C00_0C10, 32'h0000_3008, 32'h0, 1'b0, "call");
    chk("call.target", pc_f, 32'h0000_3040);
    seq(JR, 32'h0, 32'h0000_3040, 32'h0000_3010, 1'b0, "ret");
    chk("ret.count", 32'(ras_count), 32'd0);
    chk("ret.hit_cnt", jr_hit_cnt, PERF ? 32'd1 : 32'd0);

    for (int k = 0; k < 9; k++)
      seq(JAL, 32'h0C00_0C00, 32'h0000_3000 + 32'(16 * k), 32'h0, 1'b0, $sformatf("ovf_jal%0d", k));
    chk("ovf.count_full", 32'(ras_count), 32'd8);
    for (int k = 8; k >= 1; k--)
      seq(JR, 32'h0, 32'h0000_3000, 32'h0000_3008 + 32'(16 * k), 1'b0, $sformatf("ovf_jr%0d", k));
    seq(JR, 32'h0, 32'h0000_3000, 32'h0000_3008, 1'b0, "ovf_jr_empty");
    chk("ovf.hit_cnt", jr_hit_cnt, PERF ? 32'd9 : 32'd0);
    chk("ovf.miss_cnt", jr_miss_cnt, PERF ? 32'd1 : 32'd0);

    for (int s = 0; s < 3; s++)
      seq(JAL, 32'h0C00_0D00, 32'h0000_3100, 32'h0, 1'b1, $sformatf("stall_jal%0d", s));
    seq(JAL, 32'h0C00_0D00, 32'h0000_3100, 32'h0, 1'b0, "stall_rel");
    chk("stall_rel.target", pc_f, 32'h0000_3400);
    for (int s = 0; s < 2; s++)
      seq(JR, 32'h0, 32'h0000_3400, 32'h0000_3108, 1'b1, $sformatf("stall_jr%0d", s));
    seq(JR, 32'h0, 32'h0000_3400, 32'h0000_3108, 1'b0, "stall_jr_rel");

    step(JAL, 32'h0C00_0C10, 32'h0000_3200, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h0000_3020,
         32'h0000_3040, "prio_exc");
    step(PC4, 32'h0, 32'h0000_3200, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0000_3020,
         32'h0000_4184, "prio_eret");
    chk("prio.pc_f", pc_f, 32'h0000_3020);

    for (int r = 0; r < 60; r++) begin
      logic [3:0]  op;
      logic [31:0] ri, rp, rr, re;
      logic [3:0]  fl;
      logic        st, ex, er;
      op = 4'($urandom_range(0, 15));
      ri = $urandom; rp = {$urandom, 2'b00}; re = {$urandom, 2'b00};
      rr = {$urandom, 2'b00};
      if ((op == JR) && ($urandom_range(0, 2) != 0) && (m_ras.size() > 0)) rr = m_ras[$];
      fl = 4'($urandom);
      st = ($urandom_range(0, 3) == 0);
      ex = ($urandom_range(0, 15) == 0);
      er = ($urandom_range(0, 15) == 0);
      step(op, ri, rp, rr, fl, st, ex, er, re, ref_npc(op, ri, rp, rr, fl, m_pc),
           $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_pc_ras.md
Name: npc_pc_ras

Overview:
Next-generation next-PC unit for the pipelined MIPS core. It owns the F-stage PC register and computes the next PC from the D-stage instruction: branches, j/jal/jr/jalr, exception entry and eret redirects. It adds a parametrised return-address stack (RAS) that tracks call/return pairs and flags jr targets that match the predicted return. It sits between the D-stage comparator/forwarding logic and the IM address port.

Parameters:
RAS_DEPTH, 8, number of RAS entries (power of two, >=2)
RESET_PC, 32'h0000_3000, pc_f value after reset
EXC_PC, 32'h0000_4180, exception handler entry address

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard stall; hold pc_f, suppress RAS update
npc_op  in  4  0 PC4, 1 beq, 2 jal, 3 jr, 4 bgez, 5 bne, 6 blez, 7 bltz, 8 bgtz, 9 jalr, 10 j; others = PC4
ins  in  32  D-stage instruction (imm = ins[15:0], index = ins[25:0])
pc_d  in  32  PC of the D-stage instruction
rs  in  32  forwarded GPR[rs]
equ, zero_greater, zero_equ, zero_less  in  1 each  D-stage compare flags
exc_req  in  1  exception/interrupt taken this cycle
eret  in  1  eret in D
epc  in  32  CP0 EPC
pc_f  out  32  current fetch PC (registered)
npc  out  32  combinational next PC
pc8  out  32  pc_d+8 (link value)
ras_hit  out  1  jr target equals RAS top (combinational)
ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
jr_hit_cnt, jr_miss_cnt  out  32 each  perf counters (see Optional Feature)

Behaviour:
- Reset: pc_f=RESET_PC; ras_count=0; RAS pointer=0; counters=0. Reset has priority over everything.
- Combinational npc:
  - Default is pc_f+4.
  - Taken branch: pc_d+4+(sext(imm)<<2).
  - Branch taken conditions:
    - beq: equ
    - bne: !equ
    - bgez: zero_greater|zero_equ
    - blez: zero_equ|zero_less
    - bltz: zero_less
    - bgtz: zero_greater
  - Not-taken branch: pc_f+4.
  - j and jal: {pc_d[31:28], index, 2'b00}.
  - jr and jalr: rs.
- All address arithmetic is 32-bit modulo 2^32; no overflow trap.
- pc_f update per clock, priority order: reset > exc_req (EXC_PC) > eret (epc) > stall (hold) > npc.
- Accepted op: !reset & !exc_req & !eret & !stall. Only accepted ops touch the RAS or the counters.
- RAS push on accepted jal or jalr: write pc8 at pointer, pointer+1 mod RAS_DEPTH, ras_count saturates at RAS_DEPTH.
- RAS overflow: the oldest entry is silently overwritten (circular buffer).
- RAS pop on accepted jr with ras_count>0: pointer-1 mod RAS_DEPTH, ras_count-1.
- jr with an empty RAS: no state change, ras_hit=0.
- ras_hit = (npc_op==jr) & (ras_count!=0) & (top==rs). It is valid even while stalled, but has no side effect until accepted.
- The RAS never alters npc; it is prediction bookkeeping only. npc is always architecturally correct.
- Latency: npc is combinational from inputs; pc_f reflects it one cycle later.
- Stall held for N cycles: pc_f constant, RAS unchanged. One push/pop occurs on the cycle stall drops.

Optional Feature:
Macro NPC_PERF_CNT_EN.
- Defined: jr_hit_cnt increments on an accepted jr with ras_hit=1; jr_miss_cnt increments on an accepted jr with ras_hit=0. Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: no counter registers are built; both ports are tied to 32'h0.

Test Plan:
- Reset: reset=1 for 2 cycles then 0, npc_op=PC4 -> pc_f 0x3000, then 0x3004, 0x3008; ras_count=0.
- Branch taken: pc_d=0x3004, beq, equ=1, imm=0xFFFF -> npc=0x3004. Same with equ=0 and pc_f=0x3008 -> npc=0x300C.
- Call/return: pc_d=0x3008, jal, index=0x0000C10 -> npc=0x3040, ras_count=1 after accept. Then jr with rs=0x3010 -> ras_hit=1, ras_count=0; with NPC_PERF_CNT_EN, jr_hit_cnt=1.
- Overflow: 9 accepted jal with pc_d=0x3000+16k (k=0..8), then 8 jr with rs matching in LIFO order -> all 8 hit, ras_count 8->0. A 9th jr with rs=0x3008 -> ras_hit=0, miss count +1.
- Stall: jal presented with stall=1 for 3 cycles -> pc_f and ras_count unchanged; on release, pc_f=target and ras_count+1.
- Priority: exc_req=1 with eret=1, stall=1, jal -> pc_f=0x4180, no RAS push. Next cycle eret=1, epc=0x3020 -> pc_f=0x3020.
